// File: rtl/tia_d1_cell.sv
// tia_d1_cell: two-stage inverting strobed delay cell with sticky phase-overlap flag
//
// Ports:
//   clk    - colour clock; every state update happens on its rising edge
//   rst_l  - asynchronous active-low reset
//   in     - WIDTH-bit data into the phase-1 stage
//   s1     - phase-1 strobe; tap loads ~in when sampled high
//   s2     - phase-2 strobe; out loads ~tap when sampled high
//   tap    - registered first-stage value (inverted data)
//   out    - registered second-stage value (delayed, non-inverted data)
//   ovl    - sticky flag: s1 and s2 were sampled high on the same edge
module tia_d1_cell #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] TAP_RESET = '1
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic [WIDTH-1:0] in,
    input  logic             s1,
    input  logic             s2,
    output logic [WIDTH-1:0] tap,
    output logic [WIDTH-1:0] out,
    output logic             ovl
);
    // With both strobes high the second stage sees the value the first stage
    // is loading on this same edge, so data flows straight through: ~~in.
    logic [WIDTH-1:0] out_d;
    assign out_d = s1 ? in : ~tap;
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            tap <= TAP_RESET;
            out <= ~TAP_RESET;
            ovl <= 1'b0;
        end else begin
            if (s1) tap <= ~in;
            if (s2) out <= out_d;
            if (s1 && s2) ovl <= 1'b1;
        end
    end
`ifndef SYNTHESIS
    strobe_known: assert property (@(posedge clk) disable iff (!rst_l) !$isunknown({s1, s2}))
        else $error("tia_d1_cell: X on strobe");
`endif
endmodule

// File: tb/tb_tia_d1_cell.sv
// tb_tia_d1_cell: scoreboard bench for tia_d1_cell at WIDTH=1 and WIDTH=6
module tb_tia_d1_cell;
    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       s1 = 1'b0;
    logic       s2 = 1'b0;
    logic       in1 = 1'b0;
    logic [5:0] in6 = '0;
    logic       tap1, out1, ovl1;
    logic [5:0] tap6, out6;
    logic       ovl6;
    int         n_cmp = 0;
    int         n_bad = 0;

    typedef struct {
        string      nm;
        bit         w6;
        logic [5:0] tap;
        logic [5:0] out;
        logic       ovl;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    tia_d1_cell #(.WIDTH(1)) dut_a (
        .clk(clk), .rst_l(rst_l), .in(in1), .s1(s1), .s2(s2),
        .tap(tap1), .out(out1), .ovl(ovl1)
    );
    tia_d1_cell #(.WIDTH(6)) dut_b (
        .clk(clk), .rst_l(rst_l), .in(in6), .s1(s1), .s2(s2),
        .tap(tap6), .out(out6), .ovl(ovl6)
    );

    task automatic chk(input string nm, input bit w6, input logic [5:0] t, input logic [5:0] o, input logic v);
        exp_t e;
        e.nm = nm; e.w6 = w6; e.tap = t; e.out = o; e.ovl = v;
        q.push_back(e);
    endtask

    task automatic cyc(input logic i1, input logic [5:0] i6, input logic a, input logic b);
        @(negedge clk);
        in1 = i1; in6 = i6; s1 = a; s2 = b;
        @(posedge clk);
        #1;
        s1 = 1'b0; s2 = 1'b0;
    endtask

    task automatic rst_lo();
        @(posedge clk);
        #1 rst_l = 1'b0;
    endtask

    task automatic rst_hi();
        @(negedge clk);
        #1 rst_l = 1'b1;
    endtask

    always @(negedge clk) begin
        while (q.size() != 0) begin
            exp_t e;
            logic [12:0] act, req;
            e = q.pop_front();
            act = e.w6 ? {tap6, out6, ovl6} : {5'b0, tap1, 5'b0, out1, ovl1};
            req = {e.tap, e.out, e.ovl};
            n_cmp++;
            if (act !== req) begin
                n_bad++;
                $display("FAIL %s: got tap=%h out=%h ovl=%b, want tap=%h out=%h ovl=%b",
                         e.nm, act[12:7], act[6:1], act[0], req[12:7], req[6:1], req[0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        chk("reset_a", 0, 6'h01, 6'h00, 0);
        chk("reset_b", 1, 6'h3F, 6'h00, 0);
        @(negedge clk);
        #1 rst_l = 1'b1;
        chk("release_a", 0, 6'h01, 6'h00, 0);
        // basic s1 then s2
        cyc(1, 0, 1, 0); chk("s1_in1", 0, 6'h00, 6'h00, 0);
        cyc(1, 0, 0, 1); chk("s2_in1", 0, 6'h00, 6'h01, 0);
        cyc(0, 0, 1, 0); chk("s1_in0", 0, 6'h01, 6'h01, 0);
        cyc(0, 0, 0, 1); chk("s2_in0", 0, 6'h01, 6'h00, 0);
        // stage-1 hold while in changes
        cyc(1, 0, 1, 0); chk("hold_s1", 0, 6'h00, 6'h00, 0);
        cyc(0, 0, 0, 0); chk("hold_idle", 0, 6'h00, 6'h00, 0);
        cyc(0, 0, 0, 1); chk("hold_s2", 0, 6'h00, 6'h01, 0);
        // overlap and sticky ovl
        cyc(0, 0, 1, 0); chk("pre_ovl_s1", 0, 6'h01, 6'h01, 0);
        cyc(0, 0, 0, 1); chk("pre_ovl_s2", 0, 6'h01, 6'h00, 0);
        cyc(1, 0, 1, 1); chk("overlap", 0, 6'h00, 6'h01, 1);
        for (int k = 0; k < 10; k++) cyc(0, 0, k % 2 == 0, k % 2 == 1);
        chk("ovl_sticky", 0, 6'h01, 6'h00, 1);
        rst_lo();
        chk("ovl_clear_a", 0, 6'h01, 6'h00, 0);
        chk("ovl_clear_b", 1, 6'h3F, 6'h00, 0);
        cyc(1, 6'h3F, 1, 1);
        chk("strobe_in_rst_a", 0, 6'h01, 6'h00, 0);
        chk("strobe_in_rst_b", 1, 6'h3F, 6'h00, 0);
        rst_hi();
        // WIDTH=6 alternating phases
        cyc(0, 6'h2A, 1, 0); chk("w6_s1_2a", 1, 6'h15, 6'h00, 0);
        cyc(0, 6'h2A, 0, 1); chk("w6_s2_2a", 1, 6'h15, 6'h2A, 0);
        cyc(0, 6'h15, 1, 0); chk("w6_s1_15", 1, 6'h2A, 6'h2A, 0);
        cyc(0, 6'h15, 0, 1); chk("w6_s2_15", 1, 6'h2A, 6'h15, 0);
        chk("a_after_w6", 0, 6'h01, 6'h00, 0);
        // reset between s1 and s2 discards the pending value
        cyc(1, 0, 1, 0); chk("pend_s1", 0, 6'h00, 6'h00, 0);
        rst_lo();
        chk("pend_rst", 0, 6'h01, 6'h00, 0);
        rst_hi();
        cyc(0, 0, 0, 1); chk("pend_discard", 0, 6'h01, 6'h00, 0);
        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
